// File: rtl/rs_pool_pkg.sv
// Shared definitions for the reservation-station pool: packet, tag and entry types.
package rs_pool_pkg;

  localparam int unsigned RS_DEPTH = 8;
  localparam int unsigned TAG_W    = 6;
  localparam int unsigned INST_W   = 32;

  // CDB broadcast: a completing producer tag.
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
  } TAG;

  // Source operand: valid means the operand exists; ready means its value is available.
  typedef struct packed {
    logic             valid;
    logic             ready;
    logic [TAG_W-1:0] tag;
  } OPERAND;

  typedef struct packed {
    logic              valid;
    logic              illegal;
    logic [INST_W-1:0] inst;
    logic [TAG_W-1:0]  dest_tag;
    OPERAND            t1;
    OPERAND            t2;
  } ID_EX_PACKET;

  typedef struct packed {
    logic        busy;
    ID_EX_PACKET pkt;
  } rs_entry_t;

  // Operand no longer blocks issue.
  function automatic logic operand_ok(input OPERAND op);
    return !op.valid || op.ready;
  endfunction

  // Mark an operand ready when the broadcast tag matches it; absent operands never match.
  function automatic OPERAND operand_wake(input OPERAND op, input TAG bc);
    OPERAND r;
    r = op;
    if (bc.valid && op.valid && (op.tag == bc.tag)) r.ready = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/rs_age_matrix.sv
// Age matrix: tracks allocation order and grants the oldest ready entry (one-hot).
module rs_age_matrix
  import rs_pool_pkg::*;
#(
  parameter int unsigned DEPTH = RS_DEPTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear_i,
  input  logic [DEPTH-1:0] alloc_i,
  input  logic [DEPTH-1:0] ready_i,
  output logic [DEPTH-1:0] grant_o
);

  // older_q[j][i] set means entry j was allocated before entry i.
  logic [DEPTH-1:0] older_q [DEPTH];
  logic [DEPTH-1:0] older_d [DEPTH];

  // Matrix register; reset and flush wipe all ordering.
  always_ff @(posedge clock) begin
    if (reset || clear_i) begin
      for (int i = 0; i < DEPTH; i++) older_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) older_q[i] <= older_d[i];
    end
  end

  // A newly allocated entry is younger than every other entry; stale bits of free entries are masked by ready.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) older_d[i] = older_q[i];
    for (int k = 0; k < DEPTH; k++) begin
      if (alloc_i[k]) begin
        for (int j = 0; j < DEPTH; j++) begin
          older_d[k][j] = 1'b0;
          older_d[j][k] = (j != k);
        end
      end
    end
  end

  // Grant a ready entry when no older entry is also ready.
  always_comb begin
    grant_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic blocked;
      blocked = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        if ((j != i) && ready_i[j] && older_q[j][i]) blocked = 1'b1;
      end
      grant_o[i] = ready_i[i] && !blocked;
    end
  end

endmodule

// File: rtl/rs_pool.sv
// Reservation-station pool: allocate on dispatch, wake on CDB, issue oldest ready entry.
module rs_pool
  import rs_pool_pkg::*;
#(
  parameter int unsigned DEPTH         = RS_DEPTH,
  parameter bit          WAKEUP_BYPASS = 1'b1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       dispatch_valid,
  input  ID_EX_PACKET                dispatch_pkt,
  output logic                       dispatch_ready,
  input  TAG                         cdb,
  input  logic                       flush,
  input  logic                       issue_ready,
  output logic                       issue_valid,
  output ID_EX_PACKET                issue_pkt,
  output logic [$clog2(DEPTH+1)-1:0] free_count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  rs_entry_t        entry_q [DEPTH];
  rs_entry_t        entry_d [DEPTH];
  logic [CNT_W-1:0] busy_cnt_c;
  logic [DEPTH-1:0] ready_c;
  logic [DEPTH-1:0] grant_c;
  logic [DEPTH-1:0] alloc_c;
  logic             accept_c;
  logic             issue_fire_c;

  // Entry storage register.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= entry_d[i];
    end
  end

  // Occupancy status from registered busy bits only.
  always_comb begin
    busy_cnt_c = '0;
    for (int i = 0; i < DEPTH; i++) busy_cnt_c = busy_cnt_c + CNT_W'(entry_q[i].busy);
    full           = (busy_cnt_c == CNT_W'(DEPTH));
    empty          = (busy_cnt_c == '0);
    free_count     = CNT_W'(DEPTH) - busy_cnt_c;
    dispatch_ready = !full;
  end

  // Per-entry readiness: busy with all present operands available.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ready_c[i] = entry_q[i].busy && operand_ok(entry_q[i].pkt.t1) &&
                   operand_ok(entry_q[i].pkt.t2);
    end
  end

  rs_age_matrix #(.DEPTH(DEPTH)) u_age (
    .clock   (clock),
    .reset   (reset),
    .clear_i (flush),
    .alloc_i (alloc_c),
    .ready_i (ready_c),
    .grant_o (grant_c)
  );

  // Issue port: oldest ready packet, zeroed when nothing issues.
  always_comb begin
    issue_valid = (|ready_c) && !flush;
    issue_pkt   = '0;
    if (issue_valid) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (grant_c[i]) issue_pkt = entry_q[i].pkt;
      end
    end
  end

  // Dispatch acceptance and lowest-index free slot selection.
  always_comb begin
    logic found;
    found    = 1'b0;
    alloc_c  = '0;
    accept_c = dispatch_valid && !full && dispatch_pkt.valid && !dispatch_pkt.illegal && !flush;
    for (int i = 0; i < DEPTH; i++) begin
      if (!found && !entry_q[i].busy) begin
        alloc_c[i] = accept_c;
        found      = 1'b1;
      end
    end
  end

  // Next entry state: wakeup, free on issue, allocate, flush overrides everything.
  always_comb begin
    issue_fire_c = issue_valid && issue_ready;
    for (int i = 0; i < DEPTH; i++) begin
      entry_d[i] = entry_q[i];
      if (entry_q[i].busy) begin
        entry_d[i].pkt.t1 = operand_wake(entry_q[i].pkt.t1, cdb);
        entry_d[i].pkt.t2 = operand_wake(entry_q[i].pkt.t2, cdb);
      end
      if (issue_fire_c && grant_c[i]) entry_d[i].busy = 1'b0;
      if (alloc_c[i]) begin
        entry_d[i].busy = 1'b1;
        entry_d[i].pkt  = dispatch_pkt;
        if (WAKEUP_BYPASS) begin
          entry_d[i].pkt.t1 = operand_wake(dispatch_pkt.t1, cdb);
          entry_d[i].pkt.t2 = operand_wake(dispatch_pkt.t2, cdb);
        end
      end
      if (flush) entry_d[i].busy = 1'b0;
    end
  end

endmodule

// File: tb/tb_rs_pool.sv
// Self-checking bench for rs_pool (DEPTH=4) with a queue-based age-order reference model.
module tb_rs_pool;
  import rs_pool_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        dispatch_valid;
  ID_EX_PACKET dispatch_pkt;
  TAG          cdb;
  logic        flush;
  logic        issue_ready;

  logic        dispatch_ready, issue_valid, full, empty;
  ID_EX_PACKET issue_pkt;
  logic [2:0]  free_count;

  logic        nb_dispatch_ready, nb_issue_valid, nb_full, nb_empty;
  ID_EX_PACKET nb_issue_pkt;
  logic [2:0]  nb_free_count;

  int errors = 0;
  int checks = 0;

  // Reference model: packets held in allocation order (front = oldest).
  ID_EX_PACKET mq[$];

  rs_pool #(.DEPTH(DEPTH), .WAKEUP_BYPASS(1'b1)) dut (
    .clock(clock), .reset(reset), .dispatch_valid(dispatch_valid), .dispatch_pkt(dispatch_pkt),
    .dispatch_ready(dispatch_ready), .cdb(cdb), .flush(flush), .issue_ready(issue_ready),
    .issue_valid(issue_valid), .issue_pkt(issue_pkt), .free_count(free_count),
    .full(full), .empty(empty)
  );

  rs_pool #(.DEPTH(DEPTH), .WAKEUP_BYPASS(1'b0)) dut_nb (
    .clock(clock), .reset(reset), .dispatch_valid(dispatch_valid), .dispatch_pkt(dispatch_pkt),
    .dispatch_ready(nb_dispatch_ready), .cdb(cdb), .flush(flush), .issue_ready(issue_ready),
    .issue_valid(nb_issue_valid), .issue_pkt(nb_issue_pkt), .free_count(nb_free_count),
    .full(nb_full), .empty(nb_empty)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    dispatch_valid = 1'b0;
    dispatch_pkt   = '0;
    cdb            = '0;
    flush          = 1'b0;
    issue_ready    = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mq.delete();
  endtask

  function automatic ID_EX_PACKET mk(input logic [31:0] inst,
                                     input logic v1, input logic r1, input logic [5:0] g1,
                                     input logic v2, input logic r2, input logic [5:0] g2);
    ID_EX_PACKET p;
    p          = '0;
    p.valid    = 1'b1;
    p.inst     = inst;
    p.dest_tag = inst[5:0];
    p.t1.valid = v1; p.t1.ready = r1; p.t1.tag = g1;
    p.t2.valid = v2; p.t2.ready = r2; p.t2.tag = g2;
    return p;
  endfunction

  task automatic send(input ID_EX_PACKET p);
    dispatch_valid = 1'b1;
    dispatch_pkt   = p;
    tick();
    idle();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL reset_issue_valid got=%b want=0", issue_valid); end
    checks++; if (issue_pkt !== ID_EX_PACKET'('0)) begin errors++; $display("FAIL reset_issue_pkt got=%h want=0", issue_pkt); end
    checks++; if (dispatch_ready !== 1'b1) begin errors++; $display("FAIL reset_dispatch_ready got=%b want=1", dispatch_ready); end
    checks++; if (full !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL reset_full_empty got=%b%b want=01", full, empty); end
    checks++; if (free_count !== 3'd4) begin errors++; $display("FAIL reset_free_count got=%0d want=4", free_count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send(mk(32'd50, 0, 0, 0, 0, 0, 0));
    send(mk(32'd51, 1, 0, 3, 0, 0, 0));
    reset = 1'b1; dispatch_valid = 1'b1; dispatch_pkt = mk(32'd52, 0, 0, 0, 0, 0, 0);
    flush = 1'b1; issue_ready = 1'b1; cdb = '{valid: 1'b1, tag: 6'd3};
    tick();
    reset = 1'b0; idle();
    #1;
    checks++; if (empty !== 1'b1 || free_count !== 3'd4 || issue_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mid got empty=%b free=%0d iv=%b want 1/4/0", empty, free_count, issue_valid); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int n = 0; n < 4; n++) send(mk(32'd100 + 32'(n), 0, 0, 0, 0, 0, 0));
    dispatch_valid = 1'b1; dispatch_pkt = mk(32'd200, 0, 0, 0, 0, 0, 0);
    #1;
    checks++; if (full !== 1'b1 || dispatch_ready !== 1'b0 || free_count !== 3'd0) begin
      errors++; $display("FAIL fill_full got full=%b dr=%b free=%0d want 1/0/0", full, dispatch_ready, free_count); end
    tick(); idle();
    issue_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      #1;
      checks++; if (issue_valid !== 1'b1 || issue_pkt.inst !== 32'd100 + 32'(n)) begin
        errors++; $display("FAIL fill_drain%0d got iv=%b inst=%0d want 1/%0d", n, issue_valid, issue_pkt.inst, 100 + n); end
      tick();
    end
    #1;
    checks++; if (issue_valid !== 1'b0 || empty !== 1'b1) begin
      errors++; $display("FAIL fill_fifth_dropped got iv=%b empty=%b want 0/1", issue_valid, empty); end
    idle();
  endtask

  task automatic test_oldest_ready();
    do_reset();
    send(mk(32'd1, 1, 0, 6'd5, 0, 0, 0));
    send(mk(32'd2, 0, 0, 0, 0, 0, 0));
    issue_ready = 1'b1;
    #1;
    checks++; if (issue_valid !== 1'b1 || issue_pkt.inst !== 32'd2) begin
      errors++; $display("FAIL oldest_b_first got iv=%b inst=%0d want 1/2", issue_valid, issue_pkt.inst); end
    tick();
    cdb = '{valid: 1'b1, tag: 6'd5};
    #1;
    checks++; if (issue_valid !== 1'b0) begin
      errors++; $display("FAIL oldest_no_same_cycle got iv=%b want 0", issue_valid); end
    tick();
    cdb = '0;
    #1;
    checks++; if (issue_valid !== 1'b1 || issue_pkt.inst !== 32'd1) begin
      errors++; $display("FAIL oldest_a_after_cdb got iv=%b inst=%0d want 1/1", issue_valid, issue_pkt.inst); end
    tick(); idle();
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL oldest_empty got=%b want=1", empty); end
  endtask

  task automatic test_bypass();
    do_reset();
    cdb = '{valid: 1'b1, tag: 6'd7};
    send(mk(32'd3, 1, 0, 6'd7, 0, 0, 0));
    #1;
    checks++; if (issue_valid !== 1'b1 || issue_pkt.inst !== 32'd3) begin
      errors++; $display("FAIL bypass_on got iv=%b inst=%0d want 1/3", issue_valid, issue_pkt.inst); end
    for (int n = 0; n < 3; n++) begin
      checks++; if (nb_issue_valid !== 1'b0) begin
        errors++; $display("FAIL bypass_off_wait%0d got iv=%b want 0", n, nb_issue_valid); end
      tick(); #1;
    end
    cdb = '{valid: 1'b1, tag: 6'd7};
    tick(); idle(); #1;
    checks++; if (nb_issue_valid !== 1'b1 || nb_issue_pkt.inst !== 32'd3) begin
      errors++; $display("FAIL bypass_off_late_cdb got iv=%b inst=%0d want 1/3", nb_issue_valid, nb_issue_pkt.inst); end
  endtask

  task automatic test_age_reuse();
    logic [31:0] order [4];
    order[0] = 32'd10; order[1] = 32'd12; order[2] = 32'd13; order[3] = 32'd14;
    do_reset();
    send(mk(32'd10, 1, 0, 6'd9, 0, 0, 0));
    send(mk(32'd11, 0, 0, 0, 0, 0, 0));
    send(mk(32'd12, 1, 0, 6'd9, 0, 0, 0));
    send(mk(32'd13, 0, 0, 0, 1, 0, 6'd9));
    issue_ready = 1'b1;
    #1;
    checks++; if (issue_valid !== 1'b1 || issue_pkt.inst !== 32'd11) begin
      errors++; $display("FAIL reuse_issue1 got iv=%b inst=%0d want 1/11", issue_valid, issue_pkt.inst); end
    tick(); idle();
    #1;
    checks++; if (free_count !== 3'd1) begin errors++; $display("FAIL reuse_free got=%0d want=1", free_count); end
    send(mk(32'd14, 0, 0, 0, 0, 0, 0));
    cdb = '{valid: 1'b1, tag: 6'd9};
    tick(); idle();
    issue_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      #1;
      checks++; if (issue_valid !== 1'b1 || issue_pkt.inst !== order[n]) begin
        errors++; $display("FAIL reuse_order%0d got iv=%b inst=%0d want 1/%0d", n, issue_valid, issue_pkt.inst, order[n]); end
      tick();
    end
    idle();
  endtask

  task automatic test_backpressure();
    ID_EX_PACKET p;
    p = mk(32'd20, 1, 1, 6'd2, 0, 0, 0);
    do_reset();
    send(p);
    for (int n = 0; n < 3; n++) begin
      #1;
      checks++; if (issue_valid !== 1'b1 || issue_pkt !== p || free_count !== 3'd3) begin
        errors++; $display("FAIL hold%0d got iv=%b pkt=%h free=%0d want 1/%h/3", n, issue_valid, issue_pkt, free_count, p); end
      tick();
    end
    issue_ready = 1'b1;
    #1;
    checks++; if (free_count !== 3'd3) begin errors++; $display("FAIL hold_free_same_cycle got=%0d want=3", free_count); end
    tick(); idle();
    #1;
    checks++; if (free_count !== 3'd4 || empty !== 1'b1 || issue_valid !== 1'b0) begin
      errors++; $display("FAIL hold_released got free=%0d empty=%b iv=%b want 4/1/0", free_count, empty, issue_valid); end
  endtask

  task automatic test_flush();
    do_reset();
    send(mk(32'd30, 0, 0, 0, 0, 0, 0));
    send(mk(32'd31, 1, 0, 6'd1, 0, 0, 0));
    send(mk(32'd32, 0, 0, 0, 0, 0, 0));
    flush = 1'b1; issue_ready = 1'b1;
    dispatch_valid = 1'b1; dispatch_pkt = mk(32'd33, 0, 0, 0, 0, 0, 0);
    #1;
    checks++; if (issue_valid !== 1'b0 || issue_pkt !== ID_EX_PACKET'('0)) begin
      errors++; $display("FAIL flush_gates_issue got iv=%b pkt=%h want 0/0", issue_valid, issue_pkt); end
    tick(); idle();
    #1;
    checks++; if (empty !== 1'b1 || free_count !== 3'd4 || issue_valid !== 1'b0) begin
      errors++; $display("FAIL flush_after got empty=%b free=%0d iv=%b want 1/4/0", empty, free_count, issue_valid); end
  endtask

  function automatic OPERAND mdl_wake(input OPERAND op, input TAG bc);
    OPERAND r;
    r = op;
    if (bc.valid === 1'b1 && op.valid === 1'b1 && op.tag === bc.tag) r.ready = 1'b1;
    return r;
  endfunction

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      ID_EX_PACKET p, exp_pkt;
      int          k;
      logic        exp_iv, fire, accept;
      p          = '0;
      p.valid    = ($urandom % 10) != 0;
      p.illegal  = ($urandom % 10) == 0;
      p.inst     = $urandom;
      p.dest_tag = 6'($urandom);
      p.t1.valid = 1'($urandom % 2); p.t1.ready = ($urandom % 3) == 0; p.t1.tag = 6'($urandom_range(0, 3));
      p.t2.valid = 1'($urandom % 2); p.t2.ready = ($urandom % 3) == 0; p.t2.tag = 6'($urandom_range(0, 3));
      dispatch_valid = ($urandom % 10) < 7;
      dispatch_pkt   = p;
      cdb.valid      = 1'($urandom % 2);
      cdb.tag        = 6'($urandom_range(0, 3));
      flush          = ($urandom % 40) == 0;
      issue_ready    = ($urandom % 10) < 6;
      reset          = ($urandom % 200) == 0;
      #1;
      k = -1;
      for (int i = 0; i < mq.size(); i++) begin
        if (k < 0 && (!mq[i].t1.valid || mq[i].t1.ready) && (!mq[i].t2.valid || mq[i].t2.ready)) k = i;
      end
      exp_iv  = (k >= 0) && !flush;
      exp_pkt = exp_iv ? mq[k] : '0;
      checks++; if (issue_valid !== exp_iv || issue_pkt !== exp_pkt) begin
        errors++; $display("FAIL rand_issue cyc=%0d got iv=%b pkt=%h want %b/%h", cyc, issue_valid, issue_pkt, exp_iv, exp_pkt); end
      checks++; if (free_count !== 3'(DEPTH - mq.size()) || full !== (mq.size() == DEPTH) ||
                    empty !== (mq.size() == 0) || dispatch_ready !== (mq.size() != DEPTH)) begin
        errors++; $display("FAIL rand_status cyc=%0d got free=%0d full=%b empty=%b dr=%b want free=%0d", cyc,
                           free_count, full, empty, dispatch_ready, DEPTH - mq.size()); end
      fire   = exp_iv && issue_ready;
      accept = dispatch_valid && (mq.size() < DEPTH) && p.valid && !p.illegal && !flush;
      tick();
      if (reset || flush) begin
        mq.delete();
      end else begin
        if (fire) mq.delete(k);
        for (int i = 0; i < mq.size(); i++) begin
          ID_EX_PACKET e;
          e = mq[i];
          e.t1 = mdl_wake(e.t1, cdb);
          e.t2 = mdl_wake(e.t2, cdb);
          mq[i] = e;
        end
        if (accept) begin
          p.t1 = mdl_wake(p.t1, cdb);
          p.t2 = mdl_wake(p.t2, cdb);
          mq.push_back(p);
        end
      end
      reset = 1'b0;
    end
    idle();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    tick();
    test_reset();
    test_reset_mid();
    test_fill();
    test_oldest_ready();
    test_bypass();
    test_age_reuse();
    test_backpressure();
    test_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
